pipelined_addsub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream interface. The WIDTH-bit operation is split into STAGES equal carry-chained segments, one segment per register stage, so the carry path per cycle is WIDTH/STAGES bits. Full throughput is one operation per clock, with backpressure. It replaces the single-cycle 32-bit ripple adder in the ALU datapath wherever clock rate matters more than latency.

---
 rtl/pipelined_addsub.sv | 148 ++++++++++++++
 tb/tb_pipelined_addsub.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//   Two's-complement adder/subtractor split into STAGES carry-chained
//   segments of WIDTH/STAGES bits, one segment per register stage, with a
//   valid/ready stream interface and full backpressure.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle (combinational from out_ready)
//   a, b       operands (WIDTH bits)
//   cin        carry-in (add) / borrow-in (subtract)
//   sub        0: a + b + cin, 1: a - b - cin
//   out_valid  result beat valid
//   out_ready  consumer accepts the result this cycle
//   sum        result modulo 2^WIDTH
//   cout       add: carry-out; subtract: NOT borrow-out
//   ovf        signed overflow
//   zero       sum == 0

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module pipelined_addsub #(
    parameter int WIDTH  = `WORD_SIZE,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SEG  = (STAGES >= 1) ? WIDTH / STAGES : WIDTH;
    localparam int LAST = STAGES - 1;

    if ((STAGES < 1) || (STAGES > WIDTH) || (SEG * STAGES != WIDTH)) begin : g_bad_params
        $error("pipelined_addsub: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
    end

    // Stage registers: every stage carries the full operand/partial-sum words;
    // bits not yet needed (or already consumed) are optimised away.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];

    // Stage inputs: stage 0 from the ports, stage k from stage k-1.
    logic [STAGES-1:0] v_x;
    logic [STAGES-1:0] c_x;
    logic [WIDTH-1:0]  a_x [STAGES];
    logic [WIDTH-1:0]  b_x [STAGES];
    logic [WIDTH-1:0]  s_x [STAGES];

    // Stage results.
    logic [STAGES-1:0] c_d;
    logic [WIDTH-1:0]  s_d [STAGES];

    logic [STAGES-1:0] en;

    always_comb begin : stage_inputs
        v_x    = '0;
        c_x    = '0;
        v_x[0] = in_valid;
        c_x[0] = sub ? ~cin : cin;
        a_x[0] = a;
        b_x[0] = sub ? ~b : b;
        s_x[0] = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            v_x[k] = v_q[k-1];
            c_x[k] = c_q[k-1];
            a_x[k] = a_q[k-1];
            b_x[k] = b_q[k-1];
            s_x[k] = s_q[k-1];
        end
    end

    always_comb begin : seg_add
        logic [SEG:0] seg_sum;
        seg_sum = '0;
        c_d     = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            seg_sum = {1'b0, a_x[k][k*SEG +: SEG]}
                    + {1'b0, b_x[k][k*SEG +: SEG]}
                    + {{SEG{1'b0}}, c_x[k]};
            s_d[k]              = s_x[k];
            s_d[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
            c_d[k]              = seg_sum[SEG];
        end
    end

    // en[k] = ~v[k] | en[k+1] unrolled: a stage may advance when out_ready is
    // high or any stage at or after it is empty.
    always_comb begin : enable_chain
        en = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            en[k] = out_ready;
            for (int unsigned j = k; j < STAGES; j++) begin
                if (!v_q[j]) begin
                    en[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (en[k]) begin
                    v_q[k] <= v_x[k];
                    c_q[k] <= c_d[k];
                    a_q[k] <= a_x[k];
                    b_q[k] <= b_x[k];
                    s_q[k] <= s_d[k];
                end
            end
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                    && (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
    assign zero      = ~|s_q[LAST];

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;

  localparam int W = 32;
  localparam int S = 4;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct packed {
    res_t r;
    int   cyc;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0] a, b, sum;

  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  bit   lat_chk = 1'b0;
  ent_t exp_q[$];
  ent_t e_main;

  logic        sw_valid, sw_cin, sw_sub;
  logic [63:0] sw_a, sw_b;
  int          sw_pend [4];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void ok();
    total++;
    passed++;
  endfunction

  function automatic void bad(input string tag, input logic [63:0] obs, input logic [63:0] req);
    total++;
    $error("FAIL %s: observed %0h required %0h", tag, obs, req);
  endfunction

  function automatic res_t model(input int w, input logic [63:0] xa, input logic [63:0] xb,
                                 input logic xc, input logic xs);
    logic signed [67:0] ua, ub, sa, sb, ur, sr, lim, ci;
    logic [63:0] mask;
    res_t r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    ua   = {4'b0, xa & mask};
    ub   = {4'b0, xb & mask};
    ci   = {67'b0, xc};
    lim  = 68'sd1 <<< w;
    sa   = ua[w-1] ? ua - lim : ua;
    sb   = ub[w-1] ? ub - lim : ub;
    if (xs) begin
      ur     = ua - ub - ci;
      sr     = sa - sb - ci;
      r.cout = (ur >= 0);
    end else begin
      ur     = ua + ub + ci;
      sr     = sa + sb + ci;
      r.cout = (ur >= lim);
    end
    r.ovf  = (sr >= (lim >>> 1)) || (sr < -(lim >>> 1));
    r.sum  = ur[63:0] & mask;
    r.zero = (r.sum == 64'd0);
    return r;
  endfunction

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready)
        exp_q.push_back('{model(W, {32'b0, a}, {32'b0, b}, cin, sub), cyc});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) bad("unexpected_output", 0, 1); else ok();
        if (exp_q.size() > 0) begin
          e_main = exp_q.pop_front();
          if (sum !== e_main.r.sum[W-1:0]) bad("stream_sum", sum, e_main.r.sum[W-1:0]); else ok();
          if (cout !== e_main.r.cout) bad("stream_cout", cout, e_main.r.cout); else ok();
          if (ovf !== e_main.r.ovf) bad("stream_ovf", ovf, e_main.r.ovf); else ok();
          if (zero !== e_main.r.zero) bad("stream_zero", zero, e_main.r.zero); else ok();
          if (lat_chk) begin
            if ((cyc - e_main.cyc) != S) bad("stream_latency", cyc - e_main.cyc, S); else ok();
          end
        end
      end
    end
  end

  localparam int SW_W [4] = '{8, 8, 64, 32};
  localparam int SW_S [4] = '{1, 8, 4, 2};

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int GW = SW_W[g];
    localparam int GS = SW_S[g];
    logic          ir, ov, co, of, zr;
    logic [GW-1:0] sm;
    ent_t          q[$];
    ent_t          e;

    pipelined_addsub #(.WIDTH(GW), .STAGES(GS)) dut_sw (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir),
      .a(sw_a[GW-1:0]), .b(sw_b[GW-1:0]), .cin(sw_cin), .sub(sw_sub),
      .out_valid(ov), .out_ready(1'b1),
      .sum(sm), .cout(co), .ovf(of), .zero(zr)
    );

    always @(negedge clk) begin
      if (rst_n) begin
        if (sw_valid && ir)
          q.push_back('{model(GW, sw_a, sw_b, sw_cin, sw_sub), cyc});
        if (ov) begin
          if (q.size() == 0) bad("sweep_unexpected", 0, 1); else ok();
          if (q.size() > 0) begin
            e = q.pop_front();
            if (sm !== e.r.sum[GW-1:0]) bad("sweep_sum", sm, e.r.sum[GW-1:0]); else ok();
            if (co !== e.r.cout) bad("sweep_cout", co, e.r.cout); else ok();
            if (of !== e.r.ovf) bad("sweep_ovf", of, e.r.ovf); else ok();
            if (zr !== e.r.zero) bad("sweep_zero", zr, e.r.zero); else ok();
            if ((cyc - e.cyc) != GS) bad("sweep_latency", cyc - e.cyc, GS); else ok();
          end
        end
        sw_pend[g] = q.size();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                      input logic tc, input logic ts, output int waits);
    in_valid = 1'b1;
    a = ta; b = tbv; cin = tc; sub = ts;
    waits = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
    end
    if (in_ready !== 1'b1) bad("accept", in_ready, 1); else ok();
    tick();
    in_valid = 1'b0;
  endtask

  task automatic directed(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input logic tc, input logic ts,
                          input logic [W-1:0] es, input logic ec,
                          input logic eo, input logic ez);
    int w, n;
    out_ready = 1'b0;
    send(ta, tbv, tc, ts, w);
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (n != S) bad("dir_latency", n, S); else ok();
    if (sum !== es) bad("dir_sum", sum, es); else ok();
    if (cout !== ec) bad("dir_cout", cout, ec); else ok();
    if (ovf !== eo) bad("dir_ovf", ovf, eo); else ok();
    if (zero !== ez) bad("dir_zero", zero, ez); else ok();
    out_ready = 1'b1;
    tick();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() != 0) bad("drain", exp_q.size(), 0); else ok();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, stalls, acc;
    logic hit;
    rst_n = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    for (int g = 0; g < 4; g++) sw_pend[g] = 0;
    #1 rst_n = 1'b0;
    #2;
    if (out_valid !== 1'b0) bad("reset_out_valid", out_valid, 0); else ok();
    if (sum !== 32'h0) bad("reset_sum", sum, 0); else ok();
    if (cout !== 1'b0) bad("reset_cout", cout, 0); else ok();
    if (ovf !== 1'b0) bad("reset_ovf", ovf, 0); else ok();
    if (zero !== 1'b1) bad("reset_zero", zero, 1); else ok();
    tick(); tick();
    rst_n = 1'b1;
    #1;
    if (in_ready !== 1'b1) bad("ready_after_reset", in_ready, 1); else ok();

    directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    directed(32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0);

    lat_chk = 1'b1;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
      stalls += w;
    end
    if (stalls != 0) bad("stream_stalls", stalls, 0); else ok();
    wait_drain();
    lat_chk = 1'b0;

    out_ready = 1'b0;
    in_valid = 1'b1;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      hit = in_ready;
      tick();
      if (hit) begin
        acc++;
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      end
    end
    if (acc != 4) bad("bp_accepted", acc, 4); else ok();
    if (in_ready !== 1'b0) bad("bp_in_ready", in_ready, 0); else ok();
    for (int i = 0; i < 600 && (acc < 20 || exp_q.size() > 0); i++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      hit = in_valid && in_ready;
      tick();
      if (hit) begin
        acc++;
        if (acc == 20) in_valid = 1'b0;
        else begin
          a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        end
      end
    end
    if (acc != 20) bad("bp_total", acc, 20); else ok();
    if (exp_q.size() != 0) bad("bp_drain", exp_q.size(), 0); else ok();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();

    out_ready = 1'b0;
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, w);
    send(32'h3333_3333, 32'h4444_4444, 1'b1, 1'b0, w);
    send(32'h5555_5555, 32'h6666_6666, 1'b0, 1'b1, w);
    tick();
    if (out_valid !== 1'b1) bad("pre_reset_valid", out_valid, 1); else ok();
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    if (out_valid !== 1'b0) bad("mid_reset_out_valid", out_valid, 0); else ok();
    if (sum !== 32'h0) bad("mid_reset_sum", sum, 0); else ok();
    if (cout !== 1'b0) bad("mid_reset_cout", cout, 0); else ok();
    if (ovf !== 1'b0) bad("mid_reset_ovf", ovf, 0); else ok();
    if (zero !== 1'b1) bad("mid_reset_zero", zero, 1); else ok();
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) tick();
    if (out_valid !== 1'b0) bad("no_stale", out_valid, 0); else ok();
    directed(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 65536; i++) begin
      sw_valid = 1'b1;
      sw_a = {$urandom, $urandom};
      sw_b = {$urandom, $urandom};
      sw_a[7:0] = i[7:0];
      sw_b[7:0] = i[15:8];
      sw_sub = i[0] ^ i[8];
      sw_cin = i[1] ^ i[9];
      tick();
    end
    sw_valid = 1'b0;
    repeat (12) tick();
    for (int g = 0; g < 4; g++) begin
      if (sw_pend[g] != 0) bad("sweep_drain", sw_pend[g], 0); else ok();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
